// File: rtl/pkt_buffer_reader.sv
// Packet buffer read controller: accepts descriptors and walks the linked word chain
// through the address manager. It reads each word from buffer memory and emits the
// packet on an AXI-Stream master through a single-word output register.
module pkt_buffer_reader #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  // Descriptor input from the scheduler
  input  logic                  s_axis_desc_valid,
  output logic                  s_axis_desc_ready,
  input  logic [ADDR_WIDTH-1:0] s_axis_desc_addr,
  input  logic [LEN_WIDTH-1:0]  s_axis_desc_len,
  // Address manager read interface
  output logic                  m_axis_rd_en,
  output logic                  m_axis_first_word_en,
  output logic [ADDR_WIDTH-1:0] m_axis_rd_addr,
  input  logic [ADDR_WIDTH-1:0] s_axis_rd_next_addr,
  // Buffer memory read port
  output logic                  m_axis_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] m_axis_mem_addr,
  input  logic [DATA_WIDTH-1:0] s_axis_mem_data,
  // Packet stream output
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  // Status
  output logic                  m_axis_busy,
  output logic [31:0]           m_axis_pkt_count
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
  logic                    first_q, first_d;
  logic                    busy_q, busy_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [31:0]             pkt_count_q, pkt_count_d;

  logic pop;
  logic desc_ready;

  assign pop = tvalid_q & m_axis_tready;

  // Next-state, command strobes and output-register update
  always_comb begin
    state_d              = state_q;
    cur_addr_d           = cur_addr_q;
    remaining_d          = remaining_q;
    first_d              = first_q;
    busy_d               = busy_q;
    tvalid_d             = tvalid_q;
    tlast_d              = tlast_q;
    tdata_d              = tdata_q;
    pkt_count_d          = pkt_count_q;
    desc_ready           = 1'b0;
    m_axis_rd_en         = 1'b0;
    m_axis_first_word_en = 1'b0;
    m_axis_rd_addr       = '0;
    m_axis_mem_rd_en     = 1'b0;
    m_axis_mem_addr      = '0;

    // Popping the last word ends the packet
    if (pop) begin
      tvalid_d = 1'b0;
      if (tlast_q) begin
        busy_d      = 1'b0;
        pkt_count_d = pkt_count_q + 32'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        // Gated by rst so nothing is accepted while the block is being reset
        desc_ready = ~busy_q & ~rst;
        if (s_axis_desc_valid && desc_ready) begin
          cur_addr_d  = s_axis_desc_addr;
          remaining_d = s_axis_desc_len;
          first_d     = 1'b1;
          // Zero-length descriptors are consumed without any read
          if (s_axis_desc_len != '0) begin
            busy_d  = 1'b1;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        // Only fetch once the output register has room for the returning word
        if (!tvalid_q || pop) begin
          m_axis_rd_en         = 1'b1;
          m_axis_first_word_en = first_q;
          m_axis_rd_addr       = cur_addr_q;
          m_axis_mem_rd_en     = 1'b1;
          m_axis_mem_addr      = cur_addr_q;
          remaining_d          = remaining_q - 1'b1;
          first_d              = 1'b0;
          state_d              = StGap;
        end
      end
      StGap: begin
        // Memory data and link both return this cycle
        tdata_d  = s_axis_mem_data;
        tvalid_d = 1'b1;
        tlast_d  = (remaining_q == '0);
        if (remaining_q != '0) begin
          cur_addr_d = s_axis_rd_next_addr;
          state_d    = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset abandons any in-flight packet
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      first_q     <= 1'b0;
      busy_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      busy_q      <= busy_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign s_axis_desc_ready = desc_ready;
  assign m_axis_tdata      = tdata_q;
  assign m_axis_tvalid     = tvalid_q;
  assign m_axis_tlast      = tlast_q;
  assign m_axis_busy       = busy_q;
  assign m_axis_pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_pkt_buffer_reader.sv
// Directed bench for pkt_buffer_reader: per-cycle vector table plus multi-cycle sequences.
module tb_pkt_buffer_reader;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 256;
  localparam int unsigned LW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_axis_desc_valid;
  logic          s_axis_desc_ready;
  logic [AW-1:0] s_axis_desc_addr;
  logic [LW-1:0] s_axis_desc_len;
  logic          m_axis_rd_en;
  logic          m_axis_first_word_en;
  logic [AW-1:0] m_axis_rd_addr;
  logic [AW-1:0] s_axis_rd_next_addr;
  logic          m_axis_mem_rd_en;
  logic [AW-1:0] m_axis_mem_addr;
  logic [DW-1:0] s_axis_mem_data;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          m_axis_busy;
  logic [31:0]   m_axis_pkt_count;

  pkt_buffer_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_axis_desc_valid   (s_axis_desc_valid),
    .s_axis_desc_ready   (s_axis_desc_ready),
    .s_axis_desc_addr    (s_axis_desc_addr),
    .s_axis_desc_len     (s_axis_desc_len),
    .m_axis_rd_en        (m_axis_rd_en),
    .m_axis_first_word_en(m_axis_first_word_en),
    .m_axis_rd_addr      (m_axis_rd_addr),
    .s_axis_rd_next_addr (s_axis_rd_next_addr),
    .m_axis_mem_rd_en    (m_axis_mem_rd_en),
    .m_axis_mem_addr     (m_axis_mem_addr),
    .s_axis_mem_data     (s_axis_mem_data),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready),
    .m_axis_tlast        (m_axis_tlast),
    .m_axis_busy         (m_axis_busy),
    .m_axis_pkt_count    (m_axis_pkt_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Memory contents are derived from the address so every word is distinguishable
  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {8{20'hC0DE0, a}};
  endfunction

  // Buffer memory and link table; returned values are only meaningful in the
  // cycle after a read, otherwise a poison value is presented
  logic [AW-1:0] link_mem [4096];
  always @(posedge clk) begin
    s_axis_mem_data     <= m_axis_mem_rd_en ? word_of(m_axis_mem_addr) : '1;
    s_axis_rd_next_addr <= m_axis_rd_en ? link_mem[m_axis_rd_addr] : 12'hEEE;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          vld;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          rdy;
    logic          e_ready;
    logic          e_rd_en;
    logic          e_first;
    logic [AW-1:0] e_rd_addr;
    logic          e_tvalid;
    logic          e_tlast;
    logic [AW-1:0] e_taddr;
    logic          e_busy;
    logic [31:0]   e_cnt;
  } vec_t;

  vec_t vt [12];

  // Packet collector state
  logic [AW-1:0] q_rd    [$];
  logic          q_first [$];
  logic [DW-1:0] q_dat   [$];
  logic          q_last  [$];
  logic [AW-1:0] exp_q   [$];
  int gap_err, stall_rd, hold_err, mem_err, stalled;
  logic done;

  // Issue one descriptor and collect all rd_en pulses and beats until tlast pops
  task automatic run_pkt(input logic [AW-1:0] a, input logic [LW-1:0] l, input int stall);
    logic prev_rd;
    logic held;
    logic stalling;
    logic [DW-1:0] hold_d;
    q_rd.delete(); q_first.delete(); q_dat.delete(); q_last.delete();
    gap_err = 0; stall_rd = 0; hold_err = 0; mem_err = 0; stalled = 0;
    prev_rd = 1'b0; held = 1'b0; done = 1'b0; hold_d = '0;
    @(negedge clk);
    s_axis_desc_valid = 1'b1; s_axis_desc_addr = a; s_axis_desc_len = l; m_axis_tready = 1'b1;
    #1;
    chk("accept ready", {255'd0, s_axis_desc_ready}, 1);
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      s_axis_desc_valid = 1'b0;
      stalling = (q_dat.size() == 1) && (stalled < stall);
      m_axis_tready = ~stalling;
      if (stalling) stalled++;
      #1;
      if (m_axis_rd_en) begin
        q_rd.push_back(m_axis_rd_addr);
        q_first.push_back(m_axis_first_word_en);
        if (prev_rd) gap_err++;
        if (stalling) stall_rd++;
        if (!m_axis_mem_rd_en || m_axis_mem_addr != m_axis_rd_addr) mem_err++;
      end
      prev_rd = m_axis_rd_en;
      if (m_axis_tvalid && !m_axis_tready) begin
        if (held && m_axis_tdata != hold_d) hold_err++;
        held = 1'b1; hold_d = m_axis_tdata;
      end else begin
        if (held && !m_axis_tvalid) hold_err++;
        held = 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        q_dat.push_back(m_axis_tdata);
        q_last.push_back(m_axis_tlast);
        if (m_axis_tlast) done = 1'b1;
      end
    end
    chk("pkt completed", {255'd0, done}, 1);
  endtask

  // Compare collected pulses and beats against exp_q
  task automatic chk_pkt(input string nm);
    chk({nm, " rd count"}, q_rd.size(), exp_q.size());
    chk({nm, " beat count"}, q_dat.size(), exp_q.size());
    chk({nm, " rd spacing"}, gap_err, 0);
    chk({nm, " mem port"}, mem_err, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < q_rd.size()) begin
        chk($sformatf("%s rd_addr[%0d]", nm, i), q_rd[i], exp_q[i]);
        chk($sformatf("%s first[%0d]", nm, i), {255'd0, q_first[i]}, (i == 0) ? 1 : 0);
      end
      if (i < q_dat.size()) begin
        chk($sformatf("%s tdata[%0d]", nm, i), q_dat[i], word_of(exp_q[i]));
        chk($sformatf("%s tlast[%0d]", nm, i), {255'd0, q_last[i]},
            (i == exp_q.size() - 1) ? 1 : 0);
      end
    end
  endtask

  task automatic chk_after(input string nm, input logic [31:0] cnt);
    @(negedge clk);
    #1;
    chk({nm, " busy cleared"}, {255'd0, m_axis_busy}, 0);
    chk({nm, " pkt_count"}, m_axis_pkt_count, cnt);
    chk({nm, " desc_ready"}, {255'd0, s_axis_desc_ready}, 1);
  endtask

  initial begin
    int npulse;
    foreach (link_mem[i]) link_mem[i] = 12'h000;
    link_mem[12'h030] = 12'h0AB;
    link_mem[12'h010] = 12'h3A2;
    link_mem[12'h3A2] = 12'h001;
    link_mem[12'h100] = 12'h200;
    link_mem[12'h200] = 12'h300;
    link_mem[12'h300] = 12'h400;

    // Per-cycle table: single word, then zero-length followed by a 2-word packet
    vt[0]  = '{1'b1, 12'h005, 12'd1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 32'd0};
    vt[1]  = '{1'b0, 12'h000, 12'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h005, 1'b0, 1'b0, 12'h000, 1'b1, 32'd0};
    vt[2]  = '{1'b0, 12'h000, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 32'd0};
    vt[3]  = '{1'b0, 12'h000, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h005, 1'b1, 32'd0};
    vt[4]  = '{1'b1, 12'h020, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 32'd1};
    vt[5]  = '{1'b1, 12'h030, 12'd2, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 32'd1};
    vt[6]  = '{1'b0, 12'h000, 12'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h030, 1'b0, 1'b0, 12'h000, 1'b1, 32'd1};
    vt[7]  = '{1'b0, 12'h000, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 32'd1};
    vt[8]  = '{1'b0, 12'h000, 12'd0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h0AB, 1'b1, 1'b0, 12'h030, 1'b1, 32'd1};
    vt[9]  = '{1'b0, 12'h000, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 32'd1};
    vt[10] = '{1'b0, 12'h000, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h0AB, 1'b1, 32'd1};
    vt[11] = '{1'b0, 12'h000, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 32'd2};

    rst = 1'b1;
    s_axis_desc_valid = 1'b0; s_axis_desc_addr = '0; s_axis_desc_len = '0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset tvalid", {255'd0, m_axis_tvalid}, 0);
    chk("reset tdata", m_axis_tdata, 0);
    chk("reset busy", {255'd0, m_axis_busy}, 0);
    chk("reset pkt_count", m_axis_pkt_count, 0);
    chk("reset rd_en", {255'd0, m_axis_rd_en}, 0);
    chk("reset desc_ready", {255'd0, s_axis_desc_ready}, 1);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      s_axis_desc_valid = vt[i].vld;
      s_axis_desc_addr  = vt[i].addr;
      s_axis_desc_len   = vt[i].len;
      m_axis_tready     = vt[i].rdy;
      #1;
      chk($sformatf("v%0d desc_ready", i), {255'd0, s_axis_desc_ready}, {255'd0, vt[i].e_ready});
      chk($sformatf("v%0d rd_en", i), {255'd0, m_axis_rd_en}, {255'd0, vt[i].e_rd_en});
      chk($sformatf("v%0d first", i), {255'd0, m_axis_first_word_en}, {255'd0, vt[i].e_first});
      chk($sformatf("v%0d mem_rd_en", i), {255'd0, m_axis_mem_rd_en}, {255'd0, vt[i].e_rd_en});
      if (vt[i].e_rd_en) begin
        chk($sformatf("v%0d rd_addr", i), m_axis_rd_addr, vt[i].e_rd_addr);
        chk($sformatf("v%0d mem_addr", i), m_axis_mem_addr, vt[i].e_rd_addr);
      end
      chk($sformatf("v%0d tvalid", i), {255'd0, m_axis_tvalid}, {255'd0, vt[i].e_tvalid});
      if (vt[i].e_tvalid) begin
        chk($sformatf("v%0d tlast", i), {255'd0, m_axis_tlast}, {255'd0, vt[i].e_tlast});
        chk($sformatf("v%0d tdata", i), m_axis_tdata, word_of(vt[i].e_taddr));
      end
      chk($sformatf("v%0d busy", i), {255'd0, m_axis_busy}, {255'd0, vt[i].e_busy});
      chk($sformatf("v%0d pkt_count", i), m_axis_pkt_count, vt[i].e_cnt);
    end
    @(negedge clk);
    s_axis_desc_valid = 1'b0;

    // Three-word chain with arbitrary links
    exp_q = '{12'h010, 12'h3A2, 12'h001};
    run_pkt(12'h010, 12'd3, 0);
    chk_pkt("chain");
    chk_after("chain", 32'd3);

    // Four words with a 10-cycle stall on the second beat
    exp_q = '{12'h100, 12'h200, 12'h300, 12'h400};
    run_pkt(12'h100, 12'd4, 10);
    chk_pkt("bp");
    chk("bp stall cycles", stalled, 10);
    chk("bp no rd_en while full", stall_rd, 0);
    chk("bp output held", hold_err, 0);
    chk_after("bp", 32'd4);

    // Reset after the second of four reads
    @(negedge clk);
    s_axis_desc_valid = 1'b1; s_axis_desc_addr = 12'h100; s_axis_desc_len = 12'd4;
    m_axis_tready = 1'b1;
    npulse = 0;
    for (int cyc = 0; cyc < 50 && npulse < 2; cyc++) begin
      @(negedge clk);
      s_axis_desc_valid = 1'b0;
      #1;
      if (m_axis_rd_en) npulse++;
    end
    chk("rst two pulses seen", npulse, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst tvalid", {255'd0, m_axis_tvalid}, 0);
    chk("rst tlast", {255'd0, m_axis_tlast}, 0);
    chk("rst tdata", m_axis_tdata, 0);
    chk("rst busy", {255'd0, m_axis_busy}, 0);
    chk("rst pkt_count", m_axis_pkt_count, 0);
    chk("rst desc_ready", {255'd0, s_axis_desc_ready}, 1);
    npulse = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      #1;
      if (m_axis_rd_en || m_axis_mem_rd_en || m_axis_tvalid) npulse++;
    end
    chk("rst no activity", npulse, 0);
    exp_q = '{12'h005};
    run_pkt(12'h005, 12'd1, 0);
    chk_pkt("post-rst");
    chk_after("post-rst", 32'd1);

    // Counter wrap
    @(negedge clk);
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_count_q;
    #1;
    chk("wrap preload", m_axis_pkt_count, 32'hFFFF_FFFF);
    run_pkt(12'h005, 12'd1, 0);
    chk_pkt("wrap");
    chk_after("wrap", 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_buffer_reader.md
Name: pkt_buffer_reader

Overview:
- Read-side controller for the shared packet buffer. It is the consumer of the free-list address manager.
- Accepts packet descriptors (SOP address and length in words) from the scheduler.
- Walks the packet's linked word chain through the address manager's read interface, reads each word from buffer memory, and emits the packet on an AXI-Stream master.
- Every word read is reported to the address manager, so its slot returns to the free list.

Parameters:
ADDR_WIDTH, 12, buffer word address width (matches address manager)
DATA_WIDTH, 256, buffer word / stream data width
LEN_WIDTH, 12, descriptor length field width (words)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
s_axis_desc_valid  input  1  descriptor valid
s_axis_desc_ready  output  1  descriptor accept
s_axis_desc_addr  input  ADDR_WIDTH  SOP word address
s_axis_desc_len  input  LEN_WIDTH  packet length in words
m_axis_rd_en  output  1  word-read pulse to address manager
m_axis_first_word_en  output  1  asserted with m_axis_rd_en for the SOP word only
m_axis_rd_addr  output  ADDR_WIDTH  address of the word being read
s_axis_rd_next_addr  input  ADDR_WIDTH  link: address of the following word
m_axis_mem_rd_en  output  1  buffer memory read enable
m_axis_mem_addr  output  ADDR_WIDTH  buffer memory read address
s_axis_mem_data  input  DATA_WIDTH  buffer memory read data, 1-cycle latency
m_axis_tdata  output  DATA_WIDTH  stream data
m_axis_tvalid  output  1  stream valid
m_axis_tready  input  1  stream ready
m_axis_tlast  output  1  last word of packet
m_axis_busy  output  1  packet in progress
m_axis_pkt_count  output  32  packets fully emitted (wraps)

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. All outputs 0. The output register is emptied. Any in-flight packet is abandoned with no further rd_en. The address manager is reset alongside.
- FSM states:
  - IDLE: s_axis_desc_ready=1.
    - On valid&ready, latch addr into cur_addr, len into remaining, set first=1.
    - If len!=0, go to ISSUE and set busy=1.
    - If len=0, drop the descriptor silently, stay IDLE, and leave pkt_count unchanged.
  - ISSUE: wait until the output register is empty, or m_axis_tvalid&m_axis_tready this cycle. Then, for exactly one cycle:
    - rd_en=1, mem_rd_en=1, rd_addr=mem_addr=cur_addr.
    - first_word_en=first.
    - Decrement remaining; clear first. Go to GAP.
  - GAP: exactly one cycle, all strobes 0.
    - s_axis_mem_data is valid this cycle and is loaded into m_axis_tdata at the end of GAP.
    - tvalid=1 from the next cycle. tlast=1 if remaining==0.
    - If remaining!=0, cur_addr<=s_axis_rd_next_addr (valid in the cycle after each rd_en pulse) and go to ISSUE.
    - Otherwise go to IDLE.
- Command spacing:
  - Never issue rd_en in consecutive cycles. Minimum spacing is 2 cycles, so steady-state throughput is 1 word per 2 cycles with tready=1.
  - The SOP pulse is never adjacent to another command.
- Output register: holds one word. tvalid/tdata/tlast stay stable until tready. The pop is tvalid&tready.
- busy:
  - Set on accept of a nonzero-length descriptor.
  - Cleared in the cycle the tlast word pops.
  - desc_ready=1 only in IDLE with busy=0. The next descriptor is not accepted until the previous tlast has popped.
- pkt_count: +1 on each tlast pop, 32-bit wrap 0xFFFFFFFF→0.
- remaining is LEN_WIDTH wide. len=2^LEN_WIDTH-1 is legal.
- Link values are not checked. Chain integrity is the address manager's responsibility.

Test Plan:
- Single word: desc addr=0x005 len=1, tready=1 → one cycle rd_en=first_word_en=1 with rd_addr=mem_addr=0x005. tvalid 2 cycles later with tdata=mem[0x005], tlast=1. pkt_count=1, busy returns to 0.
- Chain: desc addr=0x010 len=3, links 0x010→0x3A2→0x001 → rd_en pulses 2 cycles apart at addrs 0x010, 0x3A2, 0x001. first_word_en only on the first. Three beats; tlast only on the third.
- Backpressure: len=4 with tready=0 for 10 cycles after the first beat → tdata/tvalid held stable. No further rd_en until the pop. Resuming tready=1 delivers the remaining 3 beats in order.
- Zero-length and back-to-back: desc len=0, then len=2 on the next cycle → no strobes for the first. Second packet is normal; desc_ready=0 from accept until its tlast pops. pkt_count=1.
- Reset mid-packet: rst=1 after the second of 4 rd_en pulses → next cycle all outputs 0, state IDLE, no further rd_en. A new desc after reset behaves as packet 1 (pkt_count=1 after completion).
- Counter wrap: force pkt_count=0xFFFFFFFF, send a 1-word packet → pkt_count=0x00000000.
